vga_mode_timing: RTL and testbench

Programmable VGA raster timing generator that sits directly upstream of the glyph/pattern renderers. It produces pixel counters, sync pulses and the active-video flag for one of four fixed video modes, all on one pixel clock. It also produces frame and line strobes that downstream stages use for per-frame animation state. Mode changes take effect only at a frame boundary, so the raster never tears.

---
 rtl/vga_timing_pkg.sv | 74 +++++++
 rtl/vga_mode_table.sv | 46 ++++
 rtl/vga_mode_timing.sv | 142 ++++++++++++++
 tb/tb_vga_mode_timing.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_pkg
//  Brief    : Mode timing records, the four fixed video modes, FSM state type
//             and small helpers shared by the VGA raster timing generator.
//  Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

  localparam int HW = 11;
  localparam int VW = 10;

  // One entry of the mode table: porch/sync/active widths plus sync polarity
  // (1 = positive / active-high, 0 = negative / active-low).
  typedef struct packed {
    logic [HW-1:0] h_act;
    logic [HW-1:0] h_fp;
    logic [HW-1:0] h_sync;
    logic [HW-1:0] h_bp;
    logic [VW-1:0] v_act;
    logic [VW-1:0] v_fp;
    logic [VW-1:0] v_sync;
    logic [VW-1:0] v_bp;
    logic          hpol;
    logic          vpol;
  } mode_timing_t;

  localparam mode_timing_t MODE_640X480 = '{
    h_act: 11'd640,  h_fp: 11'd16,  h_sync: 11'd96,  h_bp: 11'd48,
    v_act: 10'd480,  v_fp: 10'd10,  v_sync: 10'd2,   v_bp: 10'd33,
    hpol: 1'b0, vpol: 1'b0};

  localparam mode_timing_t MODE_800X600 = '{
    h_act: 11'd800,  h_fp: 11'd40,  h_sync: 11'd128, h_bp: 11'd88,
    v_act: 10'd600,  v_fp: 10'd1,   v_sync: 10'd4,   v_bp: 10'd23,
    hpol: 1'b1, vpol: 1'b1};

  localparam mode_timing_t MODE_1024X768 = '{
    h_act: 11'd1024, h_fp: 11'd24,  h_sync: 11'd136, h_bp: 11'd160,
    v_act: 10'd768,  v_fp: 10'd3,   v_sync: 10'd6,   v_bp: 10'd29,
    hpol: 1'b0, vpol: 1'b0};

  localparam mode_timing_t MODE_1280X720 = '{
    h_act: 11'd1280, h_fp: 11'd110, h_sync: 11'd40,  h_bp: 11'd220,
    v_act: 10'd720,  v_fp: 10'd5,   v_sync: 10'd5,   v_bp: 10'd20,
    hpol: 1'b1, vpol: 1'b1};

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Select the timing record for a 2-bit mode code.
  function automatic mode_timing_t mode_lookup(input logic [1:0] m);
    case (m)
      2'd0:    return MODE_640X480;
      2'd1:    return MODE_800X600;
      2'd2:    return MODE_1024X768;
      default: return MODE_1280X720;
    endcase
  endfunction

  // Full line length in pixel clocks.
  function automatic int unsigned h_total_of(input mode_timing_t t);
    return 32'(t.h_act) + 32'(t.h_fp) + 32'(t.h_sync) + 32'(t.h_bp);
  endfunction

  // Full frame height in lines.
  function automatic int unsigned v_total_of(input mode_timing_t t);
    return 32'(t.v_act) + 32'(t.v_fp) + 32'(t.v_sync) + 32'(t.v_bp);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_mode_table.sv
`default_nettype none
// ============================================================================
//  Module   : vga_mode_table
//  Brief    : Combinational lookup from a 2-bit mode code to the compare
//             values the raster counters need (totals, sync windows, active
//             extents, polarities).
//  Revision : 1.0 - initial release
// ============================================================================
module vga_mode_table
  import vga_timing_pkg::*;
#(
  parameter int H_BITS = 11,
  parameter int V_BITS = 10
) (
  input  logic [1:0]        mode,
  output logic [H_BITS-1:0] h_total,
  output logic [H_BITS-1:0] h_act,
  output logic [H_BITS-1:0] hs_start,
  output logic [H_BITS-1:0] hs_end,
  output logic [V_BITS-1:0] v_total,
  output logic [V_BITS-1:0] v_act,
  output logic [V_BITS-1:0] vs_start,
  output logic [V_BITS-1:0] vs_end,
  output logic              hpol,
  output logic              vpol
);

  mode_timing_t t;

  // Derive window boundaries from the porch/sync widths of the selected mode
  always_comb begin
    t        = mode_lookup(mode);
    h_total  = H_BITS'(h_total_of(t));
    h_act    = H_BITS'(t.h_act);
    hs_start = H_BITS'(32'(t.h_act) + 32'(t.h_fp));
    hs_end   = H_BITS'(32'(t.h_act) + 32'(t.h_fp) + 32'(t.h_sync));
    v_total  = V_BITS'(v_total_of(t));
    v_act    = V_BITS'(t.v_act);
    vs_start = V_BITS'(32'(t.v_act) + 32'(t.v_fp));
    vs_end   = V_BITS'(32'(t.v_act) + 32'(t.v_fp) + 32'(t.v_sync));
    hpol     = t.hpol;
    vpol     = t.vpol;
  end

endmodule
`default_nettype wire

// File: rtl/vga_mode_timing.sv
`default_nettype none
// ============================================================================
//  Module   : vga_mode_timing
//  Brief    : VGA raster timing generator for four fixed modes. Produces
//             pixel/line counters, sync pulses, active-video flag and
//             line/frame strobes. Mode changes are accepted only at the
//             frame wrap so the raster never tears.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_mode_timing
  import vga_timing_pkg::*;
#(
  parameter int H_BITS = 11,
  parameter int V_BITS = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode,
  output logic              hsync,
  output logic              vsync,
  output logic              display_on,
  output logic [H_BITS-1:0] hpos,
  output logic [V_BITS-1:0] vpos,
  output logic              line_start,
  output logic              frame_start,
  output logic [1:0]        mode_active
);

  state_t            state;

  // Last counter values of the mode being generated; reloaded with the mode.
  logic [H_BITS-1:0] h_last;
  logic [V_BITS-1:0] v_last;

  logic              line_end;
  logic              frame_end;
  logic              reload;
  logic [1:0]        sel_mode;

  logic [H_BITS-1:0] tbl_h_total;
  logic [H_BITS-1:0] tbl_h_act;
  logic [H_BITS-1:0] tbl_hs_start;
  logic [H_BITS-1:0] tbl_hs_end;
  logic [V_BITS-1:0] tbl_v_total;
  logic [V_BITS-1:0] tbl_v_act;
  logic [V_BITS-1:0] tbl_vs_start;
  logic [V_BITS-1:0] tbl_vs_end;
  logic              tbl_hpol;
  logic              tbl_vpol;

  logic [H_BITS-1:0] h_next;
  logic [V_BITS-1:0] v_next;
  logic              hsync_next;
  logic              vsync_next;
  logic              display_next;

  // Detect line/frame wrap; at a frame wrap (or leaving INIT) the requested
  // mode is the one that governs the next cycle, otherwise the latched one.
  always_comb begin
    line_end  = (hpos >= h_last);
    frame_end = (state == RUN) && line_end && (vpos >= v_last);
    reload    = (state == INIT) || frame_end;
    sel_mode  = reload ? mode : mode_active;
  end

  vga_mode_table #(
    .H_BITS (H_BITS),
    .V_BITS (V_BITS)
  ) u_mode_table (
    .mode     (sel_mode),
    .h_total  (tbl_h_total),
    .h_act    (tbl_h_act),
    .hs_start (tbl_hs_start),
    .hs_end   (tbl_hs_end),
    .v_total  (tbl_v_total),
    .v_act    (tbl_v_act),
    .vs_start (tbl_vs_start),
    .vs_end   (tbl_vs_end),
    .hpol     (tbl_hpol),
    .vpol     (tbl_vpol)
  );

  // Next raster position: restart at 0,0 on reload, else advance one pixel
  always_comb begin
    h_next = hpos + H_BITS'(1);
    v_next = vpos;
    if (reload) begin
      h_next = '0;
      v_next = '0;
    end else if (line_end) begin
      h_next = '0;
      v_next = vpos + V_BITS'(1);
    end
  end

  // Decode sync/active levels for the next position so the registered
  // outputs line up with the registered counters in the same cycle
  always_comb begin
    hsync_next   = ((h_next >= tbl_hs_start) && (h_next < tbl_hs_end)) ?
                   tbl_hpol : ~tbl_hpol;
    vsync_next   = ((v_next >= tbl_vs_start) && (v_next < tbl_vs_end)) ?
                   tbl_vpol : ~tbl_vpol;
    display_next = (h_next < tbl_h_act) && (v_next < tbl_v_act);
  end

  // FSM, counters and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= INIT;
      hpos        <= '0;
      vpos        <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      display_on  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      mode_active <= 2'd0;
      h_last      <= H_BITS'(h_total_of(MODE_640X480) - 1);
      v_last      <= V_BITS'(v_total_of(MODE_640X480) - 1);
    end else begin
      case (state)
        INIT:    state <= RUN;
        RUN:     state <= RUN;
        default: state <= INIT;
      endcase
      hpos        <= h_next;
      vpos        <= v_next;
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      display_on  <= display_next;
      line_start  <= (h_next == '0);
      frame_start <= (h_next == '0) && (v_next == '0);
      if (reload) begin
        mode_active <= mode;
        h_last      <= tbl_h_total - H_BITS'(1);
        v_last      <= tbl_v_total - V_BITS'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_mode_timing.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_mode_timing
//  Brief    : Directed self-checking bench for vga_mode_timing. Long vertical
//             stretches are skipped by briefly forcing the DUT's counter
//             registers to a chosen position just before a clock edge; the
//             DUT then advances from there on its own.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_mode_timing;

  localparam int H_BITS = 11;
  localparam int V_BITS = 10;

  logic              clk;
  logic              reset;
  logic [1:0]        mode;
  logic              hsync;
  logic              vsync;
  logic              display_on;
  logic [H_BITS-1:0] hpos;
  logic [V_BITS-1:0] vpos;
  logic              line_start;
  logic              frame_start;
  logic [1:0]        mode_active;

  int total;
  int bad;

  // Snapshot of every output: {hs,vs,de,ls,fs,mode_active[1:0],hpos,vpos}
  logic [27:0] snap;
  logic [27:0] exp;
  logic [27:0] rst_snap;

  logic [H_BITS-1:0] jh;
  logic [V_BITS-1:0] jv;

  assign snap = {hsync, vsync, display_on, line_start, frame_start,
                 mode_active, hpos, vpos};

  vga_mode_timing #(
    .H_BITS (H_BITS),
    .V_BITS (V_BITS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mode        (mode),
    .hsync       (hsync),
    .vsync       (vsync),
    .display_on  (display_on),
    .hpos        (hpos),
    .vpos        (vpos),
    .line_start  (line_start),
    .frame_start (frame_start),
    .mode_active (mode_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Place the raster at (h,v) so the next edge advances from there.
  // Called at a falling edge; returns at the following falling edge.
  task automatic jump_to(input int h, input int v);
    jh = h[H_BITS-1:0];
    jv = v[V_BITS-1:0];
    force dut.hpos = jh;
    force dut.vpos = jv;
    #1;
    release dut.hpos;
    release dut.vpos;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mode  = 2'd0;
    repeat (3) @(negedge clk);
    total++;
    if (snap !== rst_snap) begin
      bad++; $display("FAIL reset_hold got=%h exp=%h", snap, rst_snap);
    end
    reset = 1'b0;
    #1;
    total++;
    if (snap !== rst_snap) begin
      bad++; $display("FAIL init_cycle got=%h exp=%h", snap, rst_snap);
    end
    @(negedge clk);
    exp = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 11'd0, 10'd0};
    total++;
    if (snap !== exp) begin
      bad++; $display("FAIL first_run got=%h exp=%h", snap, exp);
    end
  endtask

  task automatic test_mode0_line();
    for (int h = 0; h < 800; h++) begin
      total++;
      if (hpos !== 11'(h) || vpos !== 10'd0) begin
        bad++; $display("FAIL m0_pos h=%0d got=%0d,%0d", h, hpos, vpos);
      end
      total++;
      if (display_on !== (h < 640)) begin
        bad++; $display("FAIL m0_de h=%0d got=%b exp=%b", h, display_on, (h < 640));
      end
      total++;
      if (hsync !== !(h >= 656 && h < 752)) begin
        bad++; $display("FAIL m0_hs h=%0d got=%b exp=%b", h, hsync, !(h >= 656 && h < 752));
      end
      total++;
      if (line_start !== (h == 0)) begin
        bad++; $display("FAIL m0_ls h=%0d got=%b exp=%b", h, line_start, (h == 0));
      end
      @(negedge clk);
    end
    exp = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 11'd0, 10'd1};
    total++;
    if (snap !== exp) begin
      bad++; $display("FAIL m0_line_wrap got=%h exp=%h", snap, exp);
    end
  endtask

  task automatic test_mode0_frame();
    jump_to(799, 488);
    exp = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 11'd0, 10'd489};
    total++;
    if (snap !== exp) begin bad++; $display("FAIL m0_v489 got=%h exp=%h", snap, exp); end
    jump_to(799, 489);
    exp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 11'd0, 10'd490};
    total++;
    if (snap !== exp) begin bad++; $display("FAIL m0_v490 got=%h exp=%h", snap, exp); end
    jump_to(799, 490);
    exp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 11'd0, 10'd491};
    total++;
    if (snap !== exp) begin bad++; $display("FAIL m0_v491 got=%h exp=%h", snap, exp); end
    jump_to(799, 491);
    exp = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 11'd0, 10'd492};
    total++;
    if (snap !== exp) begin bad++; $display("FAIL m0_v492 got=%h exp=%h", snap, exp); end
    jump_to(799, 523);
    exp = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 11'd0, 10'd524};
    total++;
    if (snap !== exp) begin bad++; $display("FAIL m0_v524 got=%h exp=%h", snap, exp); end
    jump_to(799, 524);
    exp = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 11'd0, 10'd0};
    total++;
    if (snap !== exp) begin bad++; $display("FAIL m0_frame_wrap got=%h exp=%h", snap, exp); end
  endtask

  task automatic test_mode_switch();
    jump_to(799, 99);
    exp = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 11'd0, 10'd100};
    total++;
    if (snap !== exp) begin bad++; $display("FAIL sw_v100 got=%h exp=%h", snap, exp); end
    mode = 2'd3;
    repeat (700) @(negedge clk);
    exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 11'd700, 10'd100};
    total++;
    if (snap !== exp) begin bad++; $display("FAIL sw_ignored_mid got=%h exp=%h", snap, exp); end
    repeat (99) @(negedge clk);
    exp = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 11'd799, 10'd100};
    total++;
    if (snap !== exp) begin bad++; $display("FAIL sw_h799 got=%h exp=%h", snap, exp); end
    @(negedge clk);
    exp = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 11'd0, 10'd101};
    total++;
    if (snap !== exp) begin bad++; $display("FAIL sw_no_line_latch got=%h exp=%h", snap, exp); end
    jump_to(799, 524);
    exp = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 11'd0, 10'd0};
    total++;
    if (snap !== exp) begin bad++; $display("FAIL sw_to_m3 got=%h exp=%h", snap, exp); end
    for (int h = 0; h < 1650; h++) begin
      total++;
      if (hpos !== 11'(h) || vpos !== 10'd0) begin
        bad++; $display("FAIL m3_pos h=%0d got=%0d,%0d", h, hpos, vpos);
      end
      total++;
      if (hsync !== (h >= 1390 && h < 1430)) begin
        bad++; $display("FAIL m3_hs h=%0d got=%b exp=%b", h, hsync, (h >= 1390 && h < 1430));
      end
      total++;
      if (display_on !== (h < 1280)) begin
        bad++; $display("FAIL m3_de h=%0d got=%b exp=%b", h, display_on, (h < 1280));
      end
      @(negedge clk);
    end
    exp = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 11'd0, 10'd1};
    total++;
    if (snap !== exp) begin bad++; $display("FAIL m3_line_wrap got=%h exp=%h", snap, exp); end
    jump_to(1649, 723);
    exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 11'd0, 10'd724};
    total++;
    if (snap !== exp) begin bad++; $display("FAIL m3_v724 got=%h exp=%h", snap, exp); end
    jump_to(1649, 724);
    exp = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 11'd0, 10'd725};
    total++;
    if (snap !== exp) begin bad++; $display("FAIL m3_v725 got=%h exp=%h", snap, exp); end
    jump_to(1649, 728);
    exp = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 11'd0, 10'd729};
    total++;
    if (snap !== exp) begin bad++; $display("FAIL m3_v729 got=%h exp=%h", snap, exp); end
    jump_to(1649, 729);
    exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 11'd0, 10'd730};
    total++;
    if (snap !== exp) begin bad++; $display("FAIL m3_v730 got=%h exp=%h", snap, exp); end
    jump_to(1649, 748);
    exp = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 11'd0, 10'd749};
    total++;
    if (snap !== exp) begin bad++; $display("FAIL m3_v749 got=%h exp=%h", snap, exp); end
    jump_to(1649, 749);
    exp = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 11'd0, 10'd0};
    total++;
    if (snap !== exp) begin bad++; $display("FAIL m3_held_wrap got=%h exp=%h", snap, exp); end
  endtask

  task automatic test_mode2();
    mode = 2'd2;
    jump_to(1649, 749);
    exp = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 11'd0, 10'd0};
    total++;
    if (snap !== exp) begin bad++; $display("FAIL sw_to_m2 got=%h exp=%h", snap, exp); end
    for (int h = 0; h < 1344; h++) begin
      total++;
      if (hpos !== 11'(h) || vpos !== 10'd0) begin
        bad++; $display("FAIL m2_pos h=%0d got=%0d,%0d", h, hpos, vpos);
      end
      total++;
      if (hsync !== !(h >= 1048 && h < 1184)) begin
        bad++; $display("FAIL m2_hs h=%0d got=%b exp=%b", h, hsync, !(h >= 1048 && h < 1184));
      end
      total++;
      if (display_on !== (h < 1024)) begin
        bad++; $display("FAIL m2_de h=%0d got=%b exp=%b", h, display_on, (h < 1024));
      end
      @(negedge clk);
    end
    exp = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 11'd0, 10'd1};
    total++;
    if (snap !== exp) begin bad++; $display("FAIL m2_line_wrap got=%h exp=%h", snap, exp); end
    jump_to(1343, 766);
    exp = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd2, 11'd0, 10'd767};
    total++;
    if (snap !== exp) begin bad++; $display("FAIL m2_v767 got=%h exp=%h", snap, exp); end
    jump_to(1343, 767);
    exp = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 11'd0, 10'd768};
    total++;
    if (snap !== exp) begin bad++; $display("FAIL m2_v768 got=%h exp=%h", snap, exp); end
    jump_to(1343, 770);
    exp = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 11'd0, 10'd771};
    total++;
    if (snap !== exp) begin bad++; $display("FAIL m2_v771 got=%h exp=%h", snap, exp); end
    jump_to(1343, 776);
    exp = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 11'd0, 10'd777};
    total++;
    if (snap !== exp) begin bad++; $display("FAIL m2_v777 got=%h exp=%h", snap, exp); end
    jump_to(1343, 805);
    exp = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 11'd0, 10'd0};
    total++;
    if (snap !== exp) begin bad++; $display("FAIL m2_frame_wrap got=%h exp=%h", snap, exp); end
  endtask

  task automatic test_reset_mid();
    mode = 2'd1;
    jump_to(1343, 805);
    exp = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 11'd0, 10'd0};
    total++;
    if (snap !== exp) begin bad++; $display("FAIL sw_to_m1 got=%h exp=%h", snap, exp); end
    jump_to(499, 300);
    exp = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 11'd500, 10'd300};
    total++;
    if (snap !== exp) begin bad++; $display("FAIL m1_mid got=%h exp=%h", snap, exp); end
    #2;
    mode  = 2'd2;
    reset = 1'b1;
    #1;
    total++;
    if (snap !== rst_snap) begin
      bad++; $display("FAIL async_reset got=%h exp=%h", snap, rst_snap);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (snap !== rst_snap) begin
      bad++; $display("FAIL reinit_cycle got=%h exp=%h", snap, rst_snap);
    end
    @(negedge clk);
    exp = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 11'd0, 10'd0};
    total++;
    if (snap !== exp) begin bad++; $display("FAIL relatch got=%h exp=%h", snap, exp); end
    @(negedge clk);
    exp = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 11'd1, 10'd0};
    total++;
    if (snap !== exp) begin bad++; $display("FAIL restart_step got=%h exp=%h", snap, exp); end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    mode     = 2'd0;
    rst_snap = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 11'd0, 10'd0};
    test_reset();
    test_mode0_line();
    test_mode0_frame();
    test_mode_switch();
    test_mode2();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
